// File: rtl/sdram_frame_reader_pkg.sv
// +--------------------------------------------------------------------+
// | sdram_frame_reader_pkg                                             |
// | Shared frame-size defaults, SDRAM rw encoding and FSM states.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sdram_frame_reader_pkg;

  localparam int unsigned DEF_FRAME_WIDTH  = 640;
  localparam int unsigned DEF_FRAME_HEIGHT = 480;
  localparam int unsigned DEF_PIXEL_BITS   = 16;
  localparam int unsigned DEF_ADDR_BITS    = 24;
  localparam int unsigned DEF_BURST_LEN    = 8;

  localparam logic SDRAM_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Counters never collapse to zero width, even for a depth of one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_frame_reader_burst_buffer.sv
// +--------------------------------------------------------------------+
// | sdram_frame_reader_burst_buffer                                    |
// | One-burst register file with wrapping pointers and full/empty.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sdram_frame_reader_burst_buffer
  import sdram_frame_reader_pkg::*;
#(
  parameter int unsigned Depth = DEF_BURST_LEN,
  parameter int unsigned Width = DEF_PIXEL_BITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_adv_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             wr_last_o,
  output logic             rd_last_o
);

  localparam int unsigned PtrW = clog2_min1(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign wr_last_o = (wr_ptr_q == PtrW'(Depth - 1));
  assign rd_last_o = (rd_ptr_q == PtrW'(Depth - 1));
  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_last_o ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_adv_i) begin
        rd_ptr_q <= rd_last_o ? '0 : rd_ptr_q + 1'b1;
      end
      case ({wr_en_i, rd_adv_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdram_frame_reader.sv
// +--------------------------------------------------------------------+
// | sdram_frame_reader                                                 |
// | Reads a frame back from SDRAM in bursts and streams raster pixels. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sdram_frame_reader
  import sdram_frame_reader_pkg::*;
#(
  parameter int unsigned FrameWidth        = DEF_FRAME_WIDTH,
  parameter int unsigned FrameHeight       = DEF_FRAME_HEIGHT,
  parameter int unsigned PixelBitWidth     = DEF_PIXEL_BITS,
  parameter int unsigned AddressWidthSDRAM = DEF_ADDR_BITS,
  parameter int unsigned BurstLengthSDRAM  = DEF_BURST_LEN,
  parameter logic [AddressWidthSDRAM-1:0] FrameBaseAddr = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_start,
  output logic                         o_enable,
  output logic                         o_rw,
  output logic [AddressWidthSDRAM-1:0] o_addr,
  input  logic                         i_busy,
  input  logic [PixelBitWidth-1:0]     i_data,
  input  logic                         i_valid,
  output logic [PixelBitWidth-1:0]     o_pixel,
  output logic                         o_pixel_valid,
  input  logic                         i_pixel_accept,
  output logic                         o_busy,
  output logic                         o_frame_done
);

  localparam int unsigned NumPixels = FrameWidth * FrameHeight;
  localparam int unsigned NumBursts = NumPixels / BurstLengthSDRAM;
  localparam int unsigned BurstIdxW = clog2_min1(NumBursts);
  localparam int unsigned AW        = AddressWidthSDRAM;

  if ((NumPixels % BurstLengthSDRAM) != 0) begin : g_bad_burst_len
    $error("frame pixel count must be a multiple of BurstLengthSDRAM");
  end

  state_e                  state_q;
  logic [BurstIdxW-1:0]    burst_idx_q;
  logic [BurstIdxW-1:0]    burst_idx_d;
  logic [AW-1:0]           addr_q;
  logic [AW-1:0]           addr_d;
  logic                    enable_q;
  logic                    rw_q;
  logic                    pixel_valid_q;
  logic                    busy_q;
  logic                    frame_done_q;

  logic                    w_wr_en;
  logic                    w_rd_adv;
  logic [PixelBitWidth-1:0] w_rd_data;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_last;
  logic                    w_rd_last;
  logic                    w_last_burst;

  // Address arithmetic is deliberately modulo 2^AW.
  always_comb begin
    burst_idx_d = burst_idx_q + 1'b1;
    addr_d      = FrameBaseAddr + AW'(burst_idx_d) * AW'(BurstLengthSDRAM);
  end

  assign w_last_burst = (burst_idx_q == BurstIdxW'(NumBursts - 1));
  assign w_wr_en      = (state_q == ST_WAIT_DATA) && i_valid && !w_full;
  assign w_rd_adv     = (state_q == ST_DRAIN) && i_pixel_accept && !w_empty;

  sdram_frame_reader_burst_buffer #(
    .Depth (BurstLengthSDRAM),
    .Width (PixelBitWidth)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (w_wr_en),
    .wr_data_i (i_data),
    .rd_adv_i  (w_rd_adv),
    .rd_data_o (w_rd_data),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .wr_last_o (w_wr_last),
    .rd_last_o (w_rd_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      burst_idx_q   <= '0;
      addr_q        <= '0;
      enable_q      <= 1'b0;
      rw_q          <= 1'b0;
      pixel_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q     <= ST_REQ;
            burst_idx_q <= '0;
            addr_q      <= FrameBaseAddr;
            enable_q    <= 1'b1;
            rw_q        <= SDRAM_RW_READ;
            busy_q      <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!i_busy) begin
            state_q  <= ST_WAIT_DATA;
            enable_q <= 1'b0;
            rw_q     <= 1'b0;
          end
        end
        ST_WAIT_DATA: begin
          if (w_wr_en && w_wr_last) begin
            state_q       <= ST_DRAIN;
            pixel_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_rd_adv && w_rd_last) begin
            pixel_valid_q <= 1'b0;
            if (w_last_burst) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              state_q     <= ST_REQ;
              burst_idx_q <= burst_idx_d;
              addr_q      <= addr_d;
              enable_q    <= 1'b1;
              rw_q        <= SDRAM_RW_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_enable      = enable_q;
  assign o_rw          = rw_q;
  assign o_addr        = addr_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_pixel       = pixel_valid_q ? w_rd_data : '0;
  assign o_busy        = busy_q;
  assign o_frame_done  = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_frame_reader.sv
// +--------------------------------------------------------------------+
// | tb_sdram_frame_reader                                              |
// | Directed + randomized bench with a frame-level SDRAM/pixel model.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sdram_frame_reader;

  localparam int FW   = 32;
  localparam int FH   = 4;
  localparam int BL   = 8;
  localparam int AW   = 24;
  localparam int PBW  = 16;
  localparam int NPIX = FW * FH;
  localparam int NB   = NPIX / BL;

  logic           CLK = 1'b0;
  logic           RST;
  logic           i_start;
  logic           o_enable;
  logic           o_rw;
  logic [AW-1:0]  o_addr;
  logic           i_busy;
  logic [PBW-1:0] i_data;
  logic           i_valid;
  logic [PBW-1:0] o_pixel;
  logic           o_pixel_valid;
  logic           i_pixel_accept;
  logic           o_busy;
  logic           o_frame_done;

  // Contents of the modelled SDRAM, indexed by word address.
  logic [PBW-1:0] mem [NPIX];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  sdram_frame_reader #(
    .FrameWidth        (FW),
    .FrameHeight       (FH),
    .PixelBitWidth     (PBW),
    .AddressWidthSDRAM (AW),
    .BurstLengthSDRAM  (BL),
    .FrameBaseAddr     (24'h0)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_start        (i_start),
    .o_enable       (o_enable),
    .o_rw           (o_rw),
    .o_addr         (o_addr),
    .i_busy         (i_busy),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_pixel        (o_pixel),
    .o_pixel_valid  (o_pixel_valid),
    .i_pixel_accept (i_pixel_accept),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enable"}, 32'(o_enable), 0);
    chk({tag, "_rw"},     32'(o_rw), 0);
    chk({tag, "_addr"},   32'(o_addr), 0);
    chk({tag, "_pv"},     32'(o_pixel_valid), 0);
    chk({tag, "_pixel"},  32'(o_pixel), 0);
    chk({tag, "_busy"},   32'(o_busy), 0);
    chk({tag, "_done"},   32'(o_frame_done), 0);
  endtask

  task automatic do_request(input int exp_addr, input int busy_cyc, input bit noise);
    int k = 0;
    while (o_enable !== 1'b1 && k < 4) begin
      tick();
      k++;
    end
    chk("req_enable", 32'(o_enable), 1);
    chk("req_rw",     32'(o_rw), 1);
    chk("req_addr",   32'(o_addr), 32'(exp_addr));
    for (int i = 0; i < busy_cyc; i++) begin
      i_busy  = 1'b1;
      i_start = noise;
      tick();
      i_start = 1'b0;
      chk("hold_enable", 32'(o_enable), 1);
      chk("hold_addr",   32'(o_addr), 32'(exp_addr));
    end
    i_busy = 1'b0;
    tick();
    i_busy = 1'b1;
    chk("req_drop", 32'(o_enable), 0);
  endtask

  task automatic send_words(input int b, input bit gaps, input bit noise);
    for (int k = 0; k < BL; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          i_valid = 1'b0;
          i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
          i_start = 1'b0;
        end
      end
      chk("pv_early", 32'(o_pixel_valid), 0);
      i_valid = 1'b1;
      i_data  = mem[b * BL + k];
      tick();
    end
    i_valid = 1'b0;
    i_data  = PBW'($urandom);
    chk("pv_latency", 32'(o_pixel_valid), 1);
  endtask

  task automatic drain(input int b, input int acc_mode, input bit noise, input bit last);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < BL && cyc < 4 * BL + 8) begin
      acc = (acc_mode == 0) ? 1'b1 : (acc_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      chk("pix_valid", 32'(o_pixel_valid), 1);
      chk("pix_data",  32'(o_pixel), 32'(mem[b * BL + idx]));
      chk("no_done",   32'(o_frame_done), 0);
      chk("busy_high", 32'(o_busy), 1);
      i_pixel_accept = acc;
      if (noise) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = PBW'($urandom);
        i_start = 1'($urandom_range(0, 1));
      end
      tick();
      i_valid = 1'b0;
      i_start = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    i_pixel_accept = 1'b0;
    chk("drain_count", 32'(idx), BL);
    if (acc_mode == 0) chk("drain_cycles", 32'(cyc), BL);
    chk("pv_drop", 32'(o_pixel_valid), 0);
    if (last) begin
      chk("done_pulse", 32'(o_frame_done), 1);
      chk("busy_fall",  32'(o_busy), 0);
      chk("done_no_en", 32'(o_enable), 0);
      tick();
      chk("done_single", 32'(o_frame_done), 0);
      chk("idle_busy",   32'(o_busy), 0);
    end else begin
      chk("next_enable", 32'(o_enable), 1);
      chk("next_addr",   32'(o_addr), 32'((b + 1) * BL));
    end
  endtask

  task automatic run_frame(input bit noise, input bit directed);
    int  busy_cyc;
    int  acc_mode;
    bit  gaps;
    bit  bn;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_latency", 32'(o_enable), 1);
    chk("busy_rise",     32'(o_busy), 1);
    for (int b = 0; b < NB; b++) begin
      busy_cyc = (directed && b == 0) ? 0 : (directed && b == 1) ? 5 : $urandom_range(0, 3);
      acc_mode = (directed && b == 0) ? 0 : (directed && b == 1) ? 1 : 2;
      gaps     = !(directed && b < 2);
      bn       = noise || (directed && b >= 4);
      do_request(b * BL, busy_cyc, bn);
      send_words(b, gaps, bn);
      drain(b, acc_mode, bn, b == NB - 1);
    end
  endtask

  initial begin
    RST            = 1'b1;
    i_start        = 1'b1;
    i_busy         = 1'b1;
    i_data         = '0;
    i_valid        = 1'b0;
    i_pixel_accept = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("reset");
    end
    RST     = 1'b0;
    i_start = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_no_enable", 32'(o_enable), 0);
    end

    // First frame: SDRAM returns the low address bits as data.
    for (int i = 0; i < NPIX; i++) mem[i] = PBW'(i);
    run_frame(1'b0, 1'b1);

    // Reset in the middle of a burst transfer, then late words.
    for (int i = 0; i < NPIX; i++) mem[i] = PBW'($urandom);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    do_request(0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = PBW'($urandom);
      tick();
    end
    RST     = 1'b1;
    i_valid = 1'b1;
    tick();
    RST = 1'b0;
    chk_all_zero("midreset");
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = PBW'($urandom);
      tick();
      chk("late_enable", 32'(o_enable), 0);
      chk("late_pv",     32'(o_pixel_valid), 0);
      chk("late_busy",   32'(o_busy), 0);
    end
    i_valid = 1'b0;

    // Second frame: random data, random timing, stray inputs throughout.
    run_frame(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
